// File: rtl/layer_compositor.sv
// Priority compositor: merges LAYERS colour-keyed sprite layers over a background,
// with frame-synchronous enable/blink configuration and a winning-layer report.
module layer_compositor #(
    parameter int                  LAYERS      = 8,
    parameter int                  COLOR_W     = 8,
    parameter logic [COLOR_W-1:0]  TRANSPARENT = 8'hFF,
    parameter int                  BLINK_BIT   = 4,
    parameter int                  FRAME_W     = 6
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          startOfFrame,
    input  logic [LAYERS-1:0]             layerDR,
    input  logic [LAYERS*COLOR_W-1:0]     layerRGB,
    input  logic [COLOR_W-1:0]            backGroundRGB,
    input  logic                          cfgWe,
    input  logic [$clog2(LAYERS)-1:0]     cfgIdx,
    input  logic                          cfgEnable,
    input  logic                          cfgBlink,
    output logic [COLOR_W-1:0]            RGBOut,
    output logic                          hitValid,
    output logic [$clog2(LAYERS)-1:0]     hitLayer,
    output logic [FRAME_W-1:0]            frameCount
);

    localparam int                IDX_W    = $clog2(LAYERS);
    localparam logic [IDX_W:0]    LAYERS_V = (IDX_W+1)'(LAYERS);

    logic [LAYERS-1:0]         shEn, shBlink, actEn, actBlink;
    logic [LAYERS-1:0]         shEnNxt, shBlinkNxt;
    logic                      idxOk;
    logic [FRAME_W-1:0]        frameCnt;

    logic [LAYERS-1:0]         vis_p0;
    logic [LAYERS-1:0]         vis_p1;
    logic [LAYERS*COLOR_W-1:0] rgb_p1;
    logic [COLOR_W-1:0]        bg_p1;
    logic                      vld_p1;

    logic [IDX_W:0]            win_p1;
    logic [IDX_W-1:0]          winIdx_p1;
    logic                      winHit_p1;

    logic [COLOR_W-1:0]        rgb_p2;
    logic                      hit_p2;
    logic [IDX_W-1:0]          idx_p2;

    // Lowest visible index wins; result is {found, index}.
    function automatic logic [IDX_W:0] pickWinner(input logic [LAYERS-1:0] vis);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (vis[i]) res = {1'b1, IDX_W'(i)};
        end
        return res;
    endfunction

    assign idxOk = ({1'b0, cfgIdx} < LAYERS_V);

    // A write landing in the startOfFrame cycle is folded into the copy.
    always_comb begin
        shEnNxt    = shEn;
        shBlinkNxt = shBlink;
        if (cfgWe && idxOk) begin
            shEnNxt[cfgIdx]    = cfgEnable;
            shBlinkNxt[cfgIdx] = cfgBlink;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            shEn     <= '1;
            shBlink  <= '0;
            actEn    <= '1;
            actBlink <= '0;
            frameCnt <= '0;
        end else begin
            shEn    <= shEnNxt;
            shBlink <= shBlinkNxt;
            if (startOfFrame) begin
                actEn    <= shEnNxt;
                actBlink <= shBlinkNxt;
                frameCnt <= frameCnt + 1'b1;
            end
        end
    end

    always_comb begin
        vis_p0 = '0;
        for (int i = 0; i < LAYERS; i++) begin
            vis_p0[i] = layerDR[i]
                      && (layerRGB[i*COLOR_W +: COLOR_W] != TRANSPARENT)
                      && actEn[i]
                      && (!actBlink[i] || !frameCnt[BLINK_BIT]);
        end
    end

    // Stage 1: visibility mask and colours
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            vis_p1 <= '0;
            rgb_p1 <= '0;
            bg_p1  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vis_p1 <= vis_p0;
            rgb_p1 <= layerRGB;
            bg_p1  <= backGroundRGB;
            vld_p1 <= 1'b1;
        end
    end

    assign win_p1    = pickWinner(vis_p1);
    assign winHit_p1 = win_p1[IDX_W];
    assign winIdx_p1 = win_p1[IDX_W-1:0];

    // Stage 2: priority selection
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_p2 <= '0;
            hit_p2 <= 1'b0;
            idx_p2 <= '0;
        end else if (vld_p1) begin
            rgb_p2 <= winHit_p1 ? rgb_p1[winIdx_p1*COLOR_W +: COLOR_W] : bg_p1;
            hit_p2 <= winHit_p1;
            idx_p2 <= winIdx_p1;
        end
    end

    assign RGBOut     = rgb_p2;
    assign hitValid   = hit_p2;
    assign hitLayer   = idx_p2;
    assign frameCount = frameCnt;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: an 8-layer instance for the main features
// and a 10-layer instance for configuration index range handling.
module tb_layer_compositor;

    logic        clk;
    logic        resetN;

    logic        sof;
    logic [7:0]  dr;
    logic [63:0] rgb;
    logic [7:0]  bg;
    logic        we;
    logic [2:0]  idx;
    logic        en;
    logic        bl;
    logic [7:0]  rgbOut;
    logic        hitV;
    logic [2:0]  hitL;
    logic [5:0]  fc;

    logic        sof10;
    logic [9:0]  dr10;
    logic [79:0] rgb10;
    logic [7:0]  bg10;
    logic        we10;
    logic [3:0]  idx10;
    logic        en10;
    logic        bl10;
    logic [7:0]  rgbOut10;
    logic        hitV10;
    logic [3:0]  hitL10;
    logic [5:0]  fc10;

    int checks;
    int errors;
    int expFc;

    layer_compositor #(.LAYERS(8)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof),
        .layerDR(dr), .layerRGB(rgb), .backGroundRGB(bg),
        .cfgWe(we), .cfgIdx(idx), .cfgEnable(en), .cfgBlink(bl),
        .RGBOut(rgbOut), .hitValid(hitV), .hitLayer(hitL), .frameCount(fc)
    );

    layer_compositor #(.LAYERS(10)) dut10 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof10),
        .layerDR(dr10), .layerRGB(rgb10), .backGroundRGB(bg10),
        .cfgWe(we10), .cfgIdx(idx10), .cfgEnable(en10), .cfgBlink(bl10),
        .RGBOut(rgbOut10), .hitValid(hitV10), .hitLayer(hitL10), .frameCount(fc10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLayers();
        dr  = '0;
        rgb = '0;
    endtask

    task automatic setLayer(input int i, input logic [7:0] c);
        dr[i]         = 1'b1;
        rgb[i*8 +: 8] = c;
    endtask

    task automatic test_reset();
        resetN = 1'b1;
        sof = 0; we = 0; idx = 0; en = 0; bl = 0;
        clearLayers();
        bg = 8'h03;
        sof10 = 0; we10 = 0; idx10 = 0; en10 = 0; bl10 = 0;
        dr10 = '0; rgb10 = '0; bg10 = 8'h03;
        #2 resetN = 1'b0;
        #1;
        checks++;
        if ({rgbOut, hitV, hitL, fc} !== 18'd0) begin
            errors++;
            $display("FAIL reset_state got rgb=%h hv=%b hl=%0d fc=%0d exp all 0", rgbOut, hitV, hitL, fc);
        end
        step();
        step();
        resetN = 1'b1;
        expFc = 0;
        step();
        checks++;
        if (rgbOut !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold got %h exp 00", rgbOut);
        end
        step();
        checks++;
        if (rgbOut !== 8'h03 || hitV !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_pixel got %h hv=%b exp 03 hv=0", rgbOut, hitV);
        end
    endtask

    task automatic test_priority();
        setLayer(2, 8'h1C);
        setLayer(5, 8'hE0);
        step();
        checks++;
        if (rgbOut !== 8'h03) begin
            errors++;
            $display("FAIL latency_1clk got %h exp 03", rgbOut);
        end
        step();
        checks++;
        if (rgbOut !== 8'h1C || hitL !== 3'd2 || hitV !== 1'b1) begin
            errors++;
            $display("FAIL priority got %h hl=%0d hv=%b exp 1c hl=2 hv=1", rgbOut, hitL, hitV);
        end
    endtask

    task automatic test_colorkey();
        rgb[2*8 +: 8] = 8'hFF;
        step();
        step();
        checks++;
        if (rgbOut !== 8'hE0 || hitL !== 3'd5 || hitV !== 1'b1) begin
            errors++;
            $display("FAIL colorkey got %h hl=%0d hv=%b exp e0 hl=5 hv=1", rgbOut, hitL, hitV);
        end
    endtask

    task automatic test_no_req();
        clearLayers();
        step();
        step();
        checks++;
        if (rgbOut !== 8'h03 || hitV !== 1'b0 || hitL !== 3'd0) begin
            errors++;
            $display("FAIL no_req got %h hv=%b hl=%0d exp 03 hv=0 hl=0", rgbOut, hitV, hitL);
        end
    endtask

    task automatic test_cfg_midframe();
        setLayer(2, 8'h1C);
        setLayer(5, 8'hE0);
        we = 1; idx = 3'd2; en = 0; bl = 0;
        step();
        we = 0;
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (rgbOut !== 8'h1C) begin
            errors++;
            $display("FAIL cfg_before_sof got %h exp 1c", rgbOut);
        end
        sof = 1;
        step();
        sof = 0;
        expFc = (expFc + 1) % 64;
        step();
        checks++;
        if (rgbOut !== 8'h1C) begin
            errors++;
            $display("FAIL cfg_sof_pixel got %h exp 1c", rgbOut);
        end
        step();
        checks++;
        if (rgbOut !== 8'hE0 || hitL !== 3'd5) begin
            errors++;
            $display("FAIL cfg_after_sof got %h hl=%0d exp e0 hl=5", rgbOut, hitL);
        end
        checks++;
        if (fc !== 6'(expFc)) begin
            errors++;
            $display("FAIL frame_inc got %0d exp %0d", fc, expFc);
        end
    endtask

    task automatic test_same_cycle();
        clearLayers();
        setLayer(3, 8'h33);
        we = 1; idx = 3'd3; en = 0; bl = 0; sof = 1;
        step();
        we = 0; sof = 0;
        expFc = (expFc + 1) % 64;
        step();
        checks++;
        if (rgbOut !== 8'h33 || hitL !== 3'd3) begin
            errors++;
            $display("FAIL same_cycle_old got %h hl=%0d exp 33 hl=3", rgbOut, hitL);
        end
        step();
        checks++;
        if (rgbOut !== 8'h03 || hitV !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_new got %h hv=%b exp 03 hv=0", rgbOut, hitV);
        end
    endtask

    task automatic test_back_to_back_sof();
        sof = 1;
        step();
        step();
        sof = 0;
        expFc = (expFc + 2) % 64;
        checks++;
        if (fc !== 6'(expFc)) begin
            errors++;
            $display("FAIL b2b_sof got %0d exp %0d", fc, expFc);
        end
    endtask

    task automatic test_reset_midstream();
        clearLayers();
        setLayer(2, 8'h1C);
        we = 1; idx = 3'd2; en = 0; bl = 0; sof = 1;
        step();
        we = 0; sof = 0;
        step();
        step();
        checks++;
        if (rgbOut !== 8'h03) begin
            errors++;
            $display("FAIL disabled_before_reset got %h exp 03", rgbOut);
        end
        #1 resetN = 1'b0;
        #1;
        checks++;
        if ({rgbOut, hitV, hitL, fc} !== 18'd0) begin
            errors++;
            $display("FAIL reset_midstream got rgb=%h hv=%b hl=%0d fc=%0d exp all 0", rgbOut, hitV, hitL, fc);
        end
        step();
        resetN = 1'b1;
        expFc = 0;
        step();
        step();
        checks++;
        if (rgbOut !== 8'h1C || hitL !== 3'd2 || hitV !== 1'b1) begin
            errors++;
            $display("FAIL reenabled got %h hl=%0d hv=%b exp 1c hl=2 hv=1", rgbOut, hitL, hitV);
        end
    endtask

    task automatic test_blink();
        logic [7:0] expPix;
        logic [7:0] expOld;
        clearLayers();
        setLayer(0, 8'h55);
        we = 1; idx = 3'd0; en = 1; bl = 1;
        step();
        we = 0;
        for (int f = 0; f < 70; f++) begin
            expOld = ((expFc >> 4) & 1) != 0 ? 8'h03 : 8'h55;
            sof = 1;
            step();
            sof = 0;
            expFc = (expFc + 1) % 64;
            expPix = ((expFc >> 4) & 1) != 0 ? 8'h03 : 8'h55;
            step();
            checks++;
            if (rgbOut !== expOld) begin
                errors++;
                $display("FAIL blink_sof_pixel frame=%0d got %h exp %h", expFc, rgbOut, expOld);
            end
            step();
            checks++;
            if (rgbOut !== expPix || fc !== 6'(expFc)) begin
                errors++;
                $display("FAIL blink frame=%0d got %h fc=%0d exp %h", expFc, rgbOut, fc, expPix);
            end
        end
    endtask

    task automatic test_idx_range();
        dr10 = '0; rgb10 = '0;
        dr10[9] = 1'b1; rgb10[9*8 +: 8] = 8'h99;
        step();
        step();
        checks++;
        if (rgbOut10 !== 8'h99 || hitL10 !== 4'd9) begin
            errors++;
            $display("FAIL idx9_visible got %h hl=%0d exp 99 hl=9", rgbOut10, hitL10);
        end
        we10 = 1; idx10 = 4'd9; en10 = 0; bl10 = 0; sof10 = 1;
        step();
        we10 = 0; sof10 = 0;
        step();
        step();
        checks++;
        if (rgbOut10 !== 8'h03 || hitV10 !== 1'b0) begin
            errors++;
            $display("FAIL idx9_write got %h hv=%b exp 03 hv=0", rgbOut10, hitV10);
        end
        dr10 = '0; rgb10 = '0;
        dr10[4] = 1'b1; rgb10[4*8 +: 8] = 8'h44;
        we10 = 1; idx10 = 4'd12; en10 = 0; sof10 = 1;
        step();
        we10 = 0; sof10 = 0;
        step();
        step();
        checks++;
        if (rgbOut10 !== 8'h44 || hitL10 !== 4'd4 || hitV10 !== 1'b1) begin
            errors++;
            $display("FAIL idx12_ignored got %h hl=%0d hv=%b exp 44 hl=4 hv=1", rgbOut10, hitL10, hitV10);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        expFc  = 0;
        test_reset();
        test_priority();
        test_colorkey();
        test_no_req();
        test_cfg_midframe();
        test_same_cycle();
        test_back_to_back_sof();
        test_reset_midstream();
        test_blink();
        test_idx_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
